// File: rtl/fifo_pkg.sv
// Shared defaults and the per-cycle operation encoding for the FIFO controller.
package fifo_pkg;
    localparam int FIFO_ADDR_WIDTH = 2;
    localparam int FIFO_DATA_WIDTH = 8;

    // {push, pop} after qualification by the flags
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;
endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_ctrl.sv
// First-word fall-through FIFO controller with registered full/empty flags.
// Define FIFO_COUNT_EN to add a registered occupancy output 'count'.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
`ifdef FIFO_COUNT_EN
    output logic [ADDR_WIDTH:0]   count,
`endif
    output logic                  empty
);
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic                  push, pop;
    fifo_op_e              op;

    // A write while full is accepted only when a pop frees the head the same edge
    assign pop        = rd & ~empty;
    assign push       = wr & (~full | rd);
    assign wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
    assign rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);

    always_comb begin
        op = OP_IDLE;
        case ({push, pop})
            2'b01:   op = OP_POP;
            2'b10:   op = OP_PUSH;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
    end

    fifo_regfile #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_regfile (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_ptr <= wr_ptr_nxt;
                    empty  <= 1'b0;
                    full   <= (wr_ptr_nxt == rd_ptr);
                end
                OP_POP: begin
                    rd_ptr <= rd_ptr_nxt;
                    full   <= 1'b0;
                    empty  <= (rd_ptr_nxt == wr_ptr);
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr_nxt;
                    rd_ptr <= rd_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (op == OP_PUSH)
            count <= count + (ADDR_WIDTH+1)'(1);
        else if (op == OP_POP)
            count <= count - (ADDR_WIDTH+1)'(1);
    end
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (depth 4, 8-bit); count checks only with FIFO_COUNT_EN.
module tb_fifo_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr, rd;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       full, empty;
`ifdef FIFO_COUNT_EN
    logic [2:0] count;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .wr_data(wr_data),
        .full   (full),
        .rd     (rd),
        .rd_data(rd_data),
`ifdef FIFO_COUNT_EN
        .count  (count),
`endif
        .empty  (empty)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef FIFO_COUNT_EN
        check(tag, 16'(count), 16'(exp));
`endif
    endtask

    // Drive one edge of stimulus, then sample 1 ns after the edge
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr      = w;
        rd      = r;
        wr_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check("flags_exclusive", 16'(full & empty), 16'h0);
    endtask

    initial begin
        logic [7:0] heads [4];
        reset = 1'b1; wr = 1'b0; rd = 1'b0; wr_data = 8'h00;
        #10 reset = 1'b0;
        #1;
        check("reset_empty", 16'(empty), 16'h1);
        check("reset_full", 16'(full), 16'h0);
        check_cnt("reset_count", 0);

        // Fill: 01..04
        step(1'b1, 1'b0, 8'h01);
        check("fwft_first", 16'(rd_data), 16'h01);
        check("push1_empty", 16'(empty), 16'h0);
        check("push1_full", 16'(full), 16'h0);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        check("push3_full", 16'(full), 16'h0);
        check_cnt("push3_count", 3);
        step(1'b1, 1'b0, 8'h04);
        check("push4_full", 16'(full), 16'h1);
        check_cnt("push4_count", 4);

        // Push while full is dropped
        step(1'b1, 1'b0, 8'h05);
        check("ovf_full", 16'(full), 16'h1);
        check("ovf_head", 16'(rd_data), 16'h01);
        check_cnt("ovf_count", 4);

        // Drain in order
        heads = '{8'h02, 8'h03, 8'h04, 8'h01};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("pop%0d_head", i + 1), 16'(rd_data), 16'(heads[i]));
            check($sformatf("pop%0d_full", i + 1), 16'(full), 16'h0);
        end
        step(1'b0, 1'b1, 8'h00);
        check("pop4_empty", 16'(empty), 16'h1);
        check("pop4_stale", 16'(rd_data), 16'(heads[3]));
        check_cnt("pop4_count", 0);

        // Pops while empty are dropped
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        check("udf_empty", 16'(empty), 16'h1);
        check("udf_full", 16'(full), 16'h0);
        check("udf_stale", 16'(rd_data), 16'h01);
        check_cnt("udf_count", 0);

        // Pointers still at slot 0: new push appears at head
        step(1'b1, 1'b0, 8'h21);
        check("after_udf_head", 16'(rd_data), 16'h21);
        step(1'b1, 1'b0, 8'h22);

        // Simultaneous push/pop with 2 entries
        step(1'b1, 1'b1, 8'hAA);
        check("both2_head", 16'(rd_data), 16'h22);
        check("both2_empty", 16'(empty), 16'h0);
        check("both2_full", 16'(full), 16'h0);
        check_cnt("both2_count", 2);
        step(1'b0, 1'b1, 8'h00);
        check("both2_tail", 16'(rd_data), 16'hAA);

        // Refill to full, then push/pop together while full
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h34);
        step(1'b1, 1'b0, 8'h35);
        check("refill_full", 16'(full), 16'h1);
        step(1'b1, 1'b1, 8'hBB);
        check("bothf_full", 16'(full), 16'h1);
        check("bothf_head", 16'(rd_data), 16'h33);
        check_cnt("bothf_count", 4);
        heads = '{8'h34, 8'h35, 8'hBB, 8'h00};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("bothf_pop%0d", i + 1), 16'(rd_data), 16'(heads[i]));
        end
        step(1'b0, 1'b1, 8'h00);
        check("bothf_drained", 16'(empty), 16'h1);

        // Async reset with 3 entries queued
        step(1'b1, 1'b0, 8'h41);
        step(1'b1, 1'b0, 8'h42);
        step(1'b1, 1'b0, 8'h43);
        check("pre_rst_empty", 16'(empty), 16'h0);
        reset = 1'b1;
        #1;
        check("async_rst_empty", 16'(empty), 16'h1);
        check("async_rst_full", 16'(full), 16'h0);
        check_cnt("async_rst_count", 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h11);
        check("post_rst_head", 16'(rd_data), 16'h11);
        check("post_rst_empty", 16'(empty), 16'h0);
        check_cnt("post_rst_count", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, SHALL set pointer width; depth = 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set entry width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 wr  input  1  SHALL request a push of wr_data at the next rising edge.
REQ-006 wr_data  input  DATA_WIDTH  SHALL carry the word to push.
REQ-007 full  output  1  SHALL be high when all 2**ADDR_WIDTH entries hold data.
REQ-008 rd  input  1  SHALL request a pop of the head entry at the next rising edge.
REQ-009 rd_data  output  DATA_WIDTH  SHALL present the head entry.
REQ-010 empty  output  1  SHALL be high when no entries hold data.

Function
REQ-011 Storage SHALL be a 2**ADDR_WIDTH x DATA_WIDTH register array with write pointer and read pointer, each ADDR_WIDTH bits, wrapping modulo depth.
REQ-012 Push SHALL occur when wr=1 and full=0: write wr_data at write pointer, increment write pointer.
REQ-013 Pop SHALL occur when rd=1 and empty=0: increment read pointer.
REQ-014 wr while full (and rd=0) SHALL be ignored: no storage write, no pointer or flag change.
REQ-015 rd while empty SHALL be ignored: no pointer or flag change.
REQ-016 rd_data SHALL be combinational (first-word fall-through): always storage[read pointer], zero-latency; valid data only when empty=0; when empty it shows the stale entry at the read pointer.
REQ-017 full and empty SHALL be registered flags updated in the same edge as the pointers.
REQ-018 Push only: empty<=0; full<=1 when the incremented write pointer equals the read pointer.
REQ-019 Pop only: full<=0; empty<=1 when the incremented read pointer equals the write pointer.
REQ-020 wr=1, rd=1, neither flag set: push and pop both occur; flags unchanged.
REQ-021 wr=1, rd=1 while empty: push only; empty<=0.
REQ-022 wr=1, rd=1 while full: pop and push both occur (head freed this cycle); full stays 1, occupancy unchanged.
REQ-023 full and empty SHALL never be simultaneously high.

Reset
REQ-024 reset=1 SHALL asynchronously clear both pointers to 0, set empty=1, full=0.
REQ-025 Storage contents SHALL NOT be reset; reset mid-operation discards all queued data.

Configuration
REQ-026 With macro FIFO_COUNT_EN defined, an extra output count (ADDR_WIDTH+1 bits) SHALL give current occupancy 0..2**ADDR_WIDTH, registered, reset to 0, +1 on push only, -1 on pop only, unchanged otherwise.
REQ-027 Without FIFO_COUNT_EN the count port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package fifo_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH constants.
REQ-029 Storage SHALL be sub-module fifo_regfile (write port: clk, we, waddr, wdata; async read port: raddr, rdata); pointers and flags stay in fifo_ctrl.

Verification
REQ-030 Reset asserted 10 ns then released -> empty=1, full=0 (count=0 if enabled).
REQ-031 ADDR_WIDTH=2: push 01,02,03,04 on consecutive edges -> full=1 after 4th edge; rd_data=01 after first push.
REQ-032 Push 05 while full -> ignored; subsequent pops return 01,02,03,04 in order; empty=1 after 4th pop.
REQ-033 Two further pops while empty -> ignored, pointers unchanged, rd_data shows stale 01 (entry 0).
REQ-034 From 2 entries, wr=rd=1 with wr_data=AA for one edge -> head advances, occupancy still 2, AA queued last; with full, same stimulus keeps full=1.
REQ-035 Assert reset while 3 entries queued -> immediately empty=1, full=0; next push of 11 yields rd_data=11.
